// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage (with riscv_pkg)
// Description : ID/EX issue stage; holds one instruction, forwards or stalls
//               on RAW hazards and muxes ALU operands.
// Revision    : 1.0 - initial release
// ============================================================================

package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_t         op;
    } alu_in_t;
endpackage

module alu_issue_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter bit FWD_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [XLEN-1:0]     in_pc_i,
    input  logic [4:0]          in_rs1_addr_i,
    input  logic [4:0]          in_rs2_addr_i,
    input  logic [XLEN-1:0]     in_rs1_data_i,
    input  logic [XLEN-1:0]     in_rs2_data_i,
    input  logic [XLEN-1:0]     in_imm_i,
    input  riscv_pkg::alu_op_t  in_op_i,
    input  logic [1:0]          in_a_sel_i,
    input  logic [1:0]          in_b_sel_i,
    input  logic [4:0]          in_rd_addr_i,
    input  logic                in_rd_we_i,
    input  logic                mem_valid_i,
    input  logic                mem_rd_we_i,
    input  logic [4:0]          mem_rd_addr_i,
    input  logic [XLEN-1:0]     mem_data_i,
    input  logic                mem_pending_i,
    input  logic                wb_valid_i,
    input  logic                wb_rd_we_i,
    input  logic [4:0]          wb_rd_addr_i,
    input  logic [XLEN-1:0]     wb_data_i,
    output riscv_pkg::alu_in_t  alu_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     out_pc_o,
    output logic [XLEN-1:0]     out_rs2_val_o,
    output logic [4:0]          out_rd_addr_o,
    output logic                out_rd_we_o
);

    localparam logic [1:0]      c_A_RS1 = 2'd0;
    localparam logic [1:0]      c_A_PC  = 2'd1;
    localparam logic [1:0]      c_B_RS2 = 2'd0;
    localparam logic [1:0]      c_B_IMM = 2'd1;
    localparam logic [1:0]      c_B_C4  = 2'd2;
    localparam logic [XLEN-1:0] c_FOUR  = XLEN'(4);

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [4:0]         r_rs1_addr;
    logic [4:0]         r_rs2_addr;
    logic [XLEN-1:0]    r_rs1_val;
    logic [XLEN-1:0]    r_rs2_val;
    logic [XLEN-1:0]    r_imm;
    riscv_pkg::alu_op_t r_op;
    logic [1:0]         r_a_sel;
    logic [1:0]         r_b_sel;
    logic [4:0]         r_rd_addr;
    logic               r_rd_we;

    logic               w_wb_wr;
    logic               w_m1, w_m2, w_w1, w_w2;
    logic               w_use1;
    logic               w_stall;
    logic               w_fire;
    logic               w_capture;
    logic [XLEN-1:0]    w_rs1_fwd;
    logic [XLEN-1:0]    w_rs2_fwd;
    logic [XLEN-1:0]    w_cap_rs1;
    logic [XLEN-1:0]    w_cap_rs2;
    logic [XLEN-1:0]    w_a;
    logic [XLEN-1:0]    w_b;

    assign w_wb_wr = wb_valid_i && wb_rd_we_i && (wb_rd_addr_i != 5'd0);
    assign w_m1    = mem_valid_i && mem_rd_we_i && (r_rs1_addr != 5'd0) && (mem_rd_addr_i == r_rs1_addr);
    assign w_m2    = mem_valid_i && mem_rd_we_i && (r_rs2_addr != 5'd0) && (mem_rd_addr_i == r_rs2_addr);
    assign w_w1    = w_wb_wr && (wb_rd_addr_i == r_rs1_addr);
    assign w_w2    = w_wb_wr && (wb_rd_addr_i == r_rs2_addr);
    // rs2 is always live because stores carry it as sideband store data
    assign w_use1  = (r_a_sel == c_A_RS1);

    generate
        if (FWD_EN) begin : g_fwd
            assign w_rs1_fwd = w_m1 ? mem_data_i : (w_w1 ? wb_data_i : r_rs1_val);
            assign w_rs2_fwd = w_m2 ? mem_data_i : (w_w2 ? wb_data_i : r_rs2_val);
            assign w_stall   = mem_pending_i && ((w_use1 && w_m1) || w_m2);
        end else begin : g_no_fwd
            assign w_rs1_fwd = r_rs1_val;
            assign w_rs2_fwd = r_rs2_val;
            assign w_stall   = (w_use1 && (w_m1 || w_w1)) || w_m2 || w_w2;
        end
    endgenerate

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_a_sel)
            c_A_RS1: w_a = w_rs1_fwd;
            c_A_PC:  w_a = r_pc;
            default: w_a = '0;
        endcase
        case (r_b_sel)
            c_B_RS2: w_b = w_rs2_fwd;
            c_B_IMM: w_b = r_imm;
            c_B_C4:  w_b = c_FOUR;
            default: w_b = '0;
        endcase
    end

    assign out_valid_o   = r_valid && !w_stall;
    assign w_fire        = out_valid_o && out_ready_i;
    assign in_ready_o    = !flush_i && (!r_valid || w_fire);
    assign w_capture     = in_valid_i && in_ready_o;

    assign alu_o.a       = w_a;
    assign alu_o.b       = w_b;
    assign alu_o.op      = r_op;
    assign out_pc_o      = r_pc;
    assign out_rs2_val_o = w_rs2_fwd;
    assign out_rd_addr_o = r_rd_addr;
    assign out_rd_we_o   = r_rd_we;

    // A WB write in the capture cycle would be missed by the register file read
    assign w_cap_rs1 = (w_wb_wr && (wb_rd_addr_i == in_rs1_addr_i)) ? wb_data_i : in_rs1_data_i;
    assign w_cap_rs2 = (w_wb_wr && (wb_rd_addr_i == in_rs2_addr_i)) ? wb_data_i : in_rs2_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_imm      <= '0;
            r_op       <= riscv_pkg::ALU_ADD;
            r_a_sel    <= '0;
            r_b_sel    <= '0;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
        end else begin
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end

            if (w_capture) begin
                r_pc       <= in_pc_i;
                r_rs1_addr <= in_rs1_addr_i;
                r_rs2_addr <= in_rs2_addr_i;
                r_rs1_val  <= w_cap_rs1;
                r_rs2_val  <= w_cap_rs2;
                r_imm      <= in_imm_i;
                r_op       <= in_op_i;
                r_a_sel    <= in_a_sel_i;
                r_b_sel    <= in_b_sel_i;
                r_rd_addr  <= in_rd_addr_i;
                r_rd_we    <= in_rd_we_i;
            end else if (r_valid && !w_fire) begin
                if (w_w1) r_rs1_val <= wb_data_i;
                if (w_w2) r_rs2_val <= wb_data_i;
            end
        end
    end

endmodule

`default_nettype wire
